uart_tx_ctrl: RTL
=================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the character width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port tx_en, input, 1 bit: permits fetching new characters from the TX FIFO.
REQ-005 The block SHALL have port baud_div, input, 16 bits: bit period is baud_div+1 clocks.
REQ-006 The block SHALL have port parity_en, input, 1 bit: appends a parity bit when set.
REQ-007 The block SHALL have port parity_odd, input, 1 bit: 1 selects odd parity, 0 selects even parity.
REQ-008 The block SHALL have port stop2, input, 1 bit: 1 selects two stop bits, 0 selects one.
REQ-009 The block SHALL have port fifo_empty, input, 1 bit: TX FIFO empty flag.
REQ-010 The block SHALL have port fifo_rd_en, output, 1 bit: TX FIFO read strobe.
REQ-011 The block SHALL have port fifo_rdata, input, DATA_WIDTH bits: FIFO read data, registered and valid in the clock after fifo_rd_en.
REQ-012 The block SHALL have port txd, output, 1 bit: serial line, idle high.
REQ-013 The block SHALL have port tx_busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port tx_done, output, 1 bit: one-clock pulse at the end of each frame.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, LOAD, START, DATA, PARITY and STOP.
REQ-016 IDLE SHALL go to FETCH when tx_en=1 and fifo_empty=0; otherwise it SHALL stay in IDLE.
REQ-017 In FETCH, fifo_rd_en SHALL be 1 for exactly one clock, then the FSM SHALL go to LOAD; fifo_rd_en SHALL be 0 in all other states.
REQ-018 LOAD SHALL capture fifo_rdata into the shift register and latch baud_div, parity_en, parity_odd and stop2 for the whole frame, then go to START.
REQ-019 Changes to the latched configuration inputs during a frame SHALL NOT affect that frame.
REQ-020 A bit counter of baud_div+1 clocks SHALL time each of START, each DATA bit, PARITY and each STOP bit; baud_div=0 gives 1 clock per bit and baud_div=0xFFFF gives 65536 clocks per bit.
REQ-021 txd SHALL be 0 in START, SHALL carry the data LSB-first in DATA (DATA_WIDTH bits), and SHALL be 1 in STOP, IDLE, FETCH and LOAD.
REQ-022 PARITY SHALL be entered only if the latched parity_en=1, and SHALL drive the XOR of the data bits for even parity or its inverse for odd parity.
REQ-023 STOP SHALL last 1 bit period, or 2 bit periods when the latched stop2=1.
REQ-024 On the last clock of STOP the FSM SHALL go to IDLE, and tx_done SHALL be 1 in the first IDLE clock.
REQ-025 For back-to-back characters, the line SHALL be high for exactly 3 clocks between frames (IDLE, FETCH, LOAD).
REQ-026 Deasserting tx_en mid-frame SHALL let the current frame complete, and no further fetch SHALL occur.
REQ-027 When fifo_empty=1 in IDLE, fifo_rd_en SHALL never be asserted, so no underflow read is possible.
REQ-028 fifo_empty is not re-checked after FETCH, and the fetched character SHALL always be transmitted.
REQ-029 txd SHALL be driven from a flop, with no combinational glitches.

Reset
REQ-030 When rst_n=0, at any time including mid-frame, the block SHALL go to IDLE immediately and set txd=1, tx_busy=0, tx_done=0 and fifo_rd_en=0.
REQ-031 Reset SHALL also clear the bit counter, the bit index, the shift register and the latched configuration.
REQ-032 After rst_n deasserts, the first fetch SHALL occur no earlier than the first rising clock edge with tx_en=1 and fifo_empty=0.

Structure
REQ-033 The FSM state enum, the bit-counter width (16) and the txd idle level constant SHALL live in the shared package uart_pkg.
REQ-034 The baud timer SHALL be implemented as the sub-module uart_baud_cnt (load, tick output) and instantiated once.
REQ-035 The FIFO SHALL NOT be instantiated inside this block; it connects at the parent level.

Verification
REQ-036 Reset: with rst_n=0 mid-DATA and baud_div=3 -> txd=1, tx_busy=0 and fifo_rd_en=0 within the same cycle; the FSM resumes from IDLE.
REQ-037 Single frame: FIFO holds 0xA5, baud_div=3, no parity, 1 stop -> txd sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 clocks; tx_done pulses once; exactly one fifo_rd_en.
REQ-038 Parity: data 0x07 with odd parity -> parity bit 0; with even parity -> parity bit 1; stop2=1 -> stop high for 2 bit periods.
REQ-039 Back-to-back: FIFO holds 0x11, 0x22, 0x33 with baud_div=0 -> three frames, a 3-clock high gap between frames, three rd_en pulses, and none after empty.
REQ-040 Mid-frame changes: toggling tx_en to 0 and baud_div to 9 during frame 1 of 2 -> frame 1 finishes at the original rate and frame 2 is not fetched until tx_en returns to 1.
REQ-041 Empty: fifo_empty=1 with tx_en=1 for 1000 clocks -> fifo_rd_en stays 0 and txd stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and constants for the UART transmitter
package uart_pkg;

  localparam int   CNT_W    = 16;
  localparam logic TXD_IDLE = 1'b1;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_FETCH  = 3'd1;
  localparam uart_state_t ST_LOAD   = 3'd2;
  localparam uart_state_t ST_START  = 3'd3;
  localparam uart_state_t ST_DATA   = 3'd4;
  localparam uart_state_t ST_PARITY = 3'd5;
  localparam uart_state_t ST_STOP   = 3'd6;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period down-counter; tick marks the last clock of a bit
module uart_baud_cnt
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit controller pulling characters from an external TX FIFO
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_en,
  input  logic [15:0]           baud_div,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  stop2,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  txd,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int               IDX_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      div_q, div_d;
  logic                  par_en_q, par_en_d;
  logic                  par_q, par_d;
  logic                  stop2_q, stop2_d;
  logic                  txd_q, txd_d;
  logic                  done_q, done_d;
  logic                  tick;
  logic                  cnt_load;
  logic [CNT_W-1:0]      cnt_div;

  // LOAD arms the first bit period with the live divider since div_q latches on the same edge.
  assign cnt_load = (state_q == ST_LOAD) ||
                    (tick && (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}));
  assign cnt_div  = (state_q == ST_LOAD) ? baud_div : div_q;

  uart_baud_cnt u_baud_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .div_i  (cnt_div),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    div_d    = div_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    stop2_d  = stop2_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_en && !fifo_empty) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        shift_d  = fifo_rdata;
        div_d    = baud_div;
        par_en_d = parity_en;
        par_d    = (^fifo_rdata) ^ parity_odd;
        stop2_d  = stop2;
        idx_d    = '0;
        state_d  = ST_START;
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        // idx_q doubles as the stop-bit counter
        if (tick) begin
          if (stop2_q && (idx_q == '0)) begin
            idx_d = IDX_W'(1);
          end else begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // txd is registered from the next state so the line never glitches.
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
      ST_PARITY: txd_d = par_q;
      default:   txd_d = TXD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      div_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      txd_q    <= TXD_IDLE;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      div_q    <= div_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      stop2_q  <= stop2_d;
      txd_q    <= txd_d;
      done_q   <= done_d;
    end
  end

  assign txd        = txd_q;
  assign tx_done    = done_q;
  assign tx_busy    = (state_q != ST_IDLE);
  assign fifo_rd_en = (state_q == ST_FETCH);

endmodule
